// File: rtl/ball_physics_pkg.sv
// Shared game constants for the paddle game: screen geometry, ball home position
// and the state encoding that the renderer also reads.
package ball_physics_pkg;

    localparam int SCREEN_W = 96;
    localparam int SCREEN_H = 64;
    localparam int CENTRE_X = 48;
    localparam int CENTRE_Y = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_PLAY = 2'd1;
    localparam logic [1:0] ST_MISS = 2'd2;
    localparam logic [1:0] ST_OVER = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        PLAY = ST_PLAY,
        MISS = ST_MISS,
        OVER = ST_OVER
    } state_t;

    // One unit step along an axis; neg selects the decrementing direction.
    function automatic logic [6:0] step_x(input logic [6:0] p, input logic neg);
        return neg ? p - 7'd1 : p + 7'd1;
    endfunction

    function automatic logic [5:0] step_y(input logic [5:0] p, input logic neg);
        return neg ? p - 6'd1 : p + 6'd1;
    endfunction

endpackage

// File: rtl/ball_physics_if.sv
// Game-step strobes, bar bounds in, and ball/score status out.
interface ball_physics_if;
    import ball_physics_pkg::*;

    logic       tick;
    logic       start;
    logic [6:0] x_left;
    logic [6:0] x_right;
    logic [6:0] ball_x;
    logic [5:0] ball_y;
    logic [7:0] score;
    logic [1:0] lives;
    logic       hit;
    logic       game_over;

    modport master (
        output tick, start, x_left, x_right,
        input  ball_x, ball_y, score, lives, hit, game_over
    );

    modport slave (
        input  tick, start, x_left, x_right,
        output ball_x, ball_y, score, lives, hit, game_over
    );

endinterface

// File: rtl/ball_physics.sv
// Single-ball bounce engine: moves one step per tick, reflects off walls and the
// bar, counts hits and lives, and holds the ball parked between lives.
module ball_physics
    import ball_physics_pkg::*;
#(
    parameter int BAR_Y       = 58,
    parameter int START_LIVES = 3,
    parameter int MISS_TICKS  = 32
) (
    input  logic          clk,
    input  logic          reset,
    ball_physics_if.slave bus
);

    localparam logic [6:0] HOME_X   = 7'(CENTRE_X);
    localparam logic [5:0] HOME_Y   = 6'(CENTRE_Y);
    localparam logic [6:0] RIGHT_X  = 7'(SCREEN_W - 1);
    localparam logic [5:0] BOTTOM_Y = 6'(SCREEN_H - 1);
    localparam logic [5:0] ABOVE_Y  = 6'(BAR_Y - 1);
    localparam logic [1:0] LIVES0   = 2'(START_LIVES);
    localparam logic [7:0] MISS_END = 8'(MISS_TICKS - 1);

    state_t     state;
    logic [6:0] ball_x;
    logic [5:0] ball_y;
    logic       dx_neg, dy_neg;
    logic [7:0] score;
    logic [1:0] lives;
    logic       hit, game_over;
    logic [7:0] miss_cnt;

    logic       ndx_neg, ndy_neg, bar_hit;

    // Reflections resolve on the pre-move position, so the step uses the new direction.
    always_comb begin
        ndx_neg = dx_neg;
        if (ball_x == 7'd0 && dx_neg)
            ndx_neg = 1'b0;
        else if (ball_x == RIGHT_X && !dx_neg)
            ndx_neg = 1'b1;

        bar_hit = (ball_y == ABOVE_Y) && !dy_neg &&
                  (ball_x >= bus.x_left) && (ball_x <= bus.x_right);
        ndy_neg = dy_neg;
        if (ball_y == 6'd0 && dy_neg)
            ndy_neg = 1'b0;
        else if (bar_hit)
            ndy_neg = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            ball_x    <= HOME_X;
            ball_y    <= HOME_Y;
            dx_neg    <= 1'b0;
            dy_neg    <= 1'b0;
            score     <= 8'd0;
            lives     <= LIVES0;
            hit       <= 1'b0;
            game_over <= 1'b0;
            miss_cnt  <= 8'd0;
        end else begin
            hit <= 1'b0;
            case (state)
                IDLE: if (bus.start) begin
                    state  <= PLAY;
                    dx_neg <= 1'b0;
                    dy_neg <= 1'b0;
                end
                PLAY: if (bus.tick) begin
                    if (ball_y == BOTTOM_Y) begin
                        lives    <= lives - 2'd1;
                        ball_x   <= HOME_X;
                        ball_y   <= HOME_Y;
                        miss_cnt <= 8'd0;
                        if (lives == 2'd1) begin
                            state     <= OVER;
                            game_over <= 1'b1;
                        end else begin
                            state <= MISS;
                        end
                    end else begin
                        dx_neg <= ndx_neg;
                        dy_neg <= ndy_neg;
                        ball_x <= step_x(ball_x, ndx_neg);
                        ball_y <= step_y(ball_y, ndy_neg);
                        if (bar_hit) begin
                            hit <= 1'b1;
                            if (score != 8'hFF)
                                score <= score + 8'd1;
                        end
                    end
                end
                MISS: if (bus.tick) begin
                    if (miss_cnt == MISS_END) begin
                        state  <= PLAY;
                        dy_neg <= 1'b0;
                    end else begin
                        miss_cnt <= miss_cnt + 8'd1;
                    end
                end
                OVER: if (bus.start) begin
                    state     <= PLAY;
                    score     <= 8'd0;
                    lives     <= LIVES0;
                    game_over <= 1'b0;
                    ball_x    <= HOME_X;
                    ball_y    <= HOME_Y;
                    dx_neg    <= 1'b0;
                    dy_neg    <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.ball_x    = ball_x;
    assign bus.ball_y    = ball_y;
    assign bus.score     = score;
    assign bus.lives     = lives;
    assign bus.hit       = hit;
    assign bus.game_over = game_over;

endmodule

// File: tb/tb_ball_physics.sv
// Directed bench for ball_physics: launch, bar hit, wall bounce, miss/relaunch,
// game over and restart, and reset on a tick cycle.
module tb_ball_physics;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    ball_physics_if bus();

    ball_physics #(.BAR_Y(58), .START_LIVES(3), .MISS_TICKS(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_ball(input string tag, input int x, input int y);
        check({tag, ".x"}, 32'(bus.ball_x), 32'(x));
        check({tag, ".y"}, 32'(bus.ball_y), 32'(y));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are read at the same point.
    task automatic cycle(input logic t, input logic s);
        bus.tick  = t;
        bus.start = s;
        @(posedge clk);
        #1;
        bus.tick  = 1'b0;
        bus.start = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cycle(1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle(1'b0, 1'b0);
        cycle(1'b0, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        bus.tick    = 1'b0;
        bus.start   = 1'b0;
        bus.x_left  = 7'd65;
        bus.x_right = 7'd79;
        @(posedge clk);
        #1;
        do_reset();

        // Reset state and IDLE ignores tick
        check_ball("rst_ball", 48, 32);
        check("rst_score", 32'(bus.score), 0);
        check("rst_lives", 32'(bus.lives), 3);
        check("rst_hit", 32'(bus.hit), 0);
        check("rst_over", 32'(bus.game_over), 0);
        ticks(2);
        check_ball("idle_tick", 48, 32);

        // Launch and bar hit on 65..79
        cycle(1'b0, 1'b1);
        check_ball("launch_hold", 48, 32);
        ticks(1);
        check_ball("t1", 49, 33);
        check("t1_score", 32'(bus.score), 0);
        check("t1_lives", 32'(bus.lives), 3);
        ticks(24);
        check_ball("t25", 73, 57);
        check("t25_hit", 32'(bus.hit), 0);
        ticks(1);
        check_ball("t26", 74, 56);
        check("t26_score", 32'(bus.score), 1);
        check("t26_hit", 32'(bus.hit), 1);
        cycle(1'b0, 1'b0);
        check("hit_clear", 32'(bus.hit), 0);
        check_ball("no_tick_hold", 74, 56);

        // Right wall
        ticks(21);
        check_ball("t47", 95, 35);
        ticks(1);
        check_ball("t48", 94, 34);
        ticks(1);
        check_ball("t49_left", 93, 33);

        // Miss with bar 3..17
        do_reset();
        bus.x_left  = 7'd3;
        bus.x_right = 7'd17;
        cycle(1'b0, 1'b1);
        ticks(31);
        check_ball("m_t31", 79, 63);
        check("m_t31_lives", 32'(bus.lives), 3);
        ticks(1);
        check_ball("m_t32", 48, 32);
        check("m_t32_lives", 32'(bus.lives), 2);
        check("m_t32_score", 32'(bus.score), 0);
        cycle(1'b0, 1'b1);
        ticks(31);
        check_ball("m_hold31", 48, 32);
        ticks(1);
        check_ball("m_hold32", 48, 32);
        ticks(1);
        check_ball("m_resume", 49, 33);

        // Second and third misses end the game
        ticks(31);
        check("m2_lives", 32'(bus.lives), 1);
        check("m2_over", 32'(bus.game_over), 0);
        ticks(64);
        check("m3_lives", 32'(bus.lives), 0);
        check("m3_over", 32'(bus.game_over), 1);
        check_ball("m3_ball", 48, 32);
        ticks(5);
        check("over_lives", 32'(bus.lives), 0);
        check("over_flag", 32'(bus.game_over), 1);
        check_ball("over_ball", 48, 32);
        check("over_score", 32'(bus.score), 0);

        // Restart with coincident tick: launch only, no movement
        cycle(1'b1, 1'b1);
        check("rs_lives", 32'(bus.lives), 3);
        check("rs_score", 32'(bus.score), 0);
        check("rs_over", 32'(bus.game_over), 0);
        check_ball("rs_ball", 48, 32);
        ticks(1);
        check_ball("rs_t1", 49, 33);

        // Reset asserted on a tick cycle
        ticks(8);
        check_ball("pre_rst", 57, 41);
        reset = 1'b1;
        cycle(1'b1, 1'b0);
        reset = 1'b0;
        check_ball("mid_rst", 48, 32);
        check("mid_rst_lives", 32'(bus.lives), 3);
        check("mid_rst_score", 32'(bus.score), 0);
        check("mid_rst_over", 32'(bus.game_over), 0);
        ticks(1);
        check_ball("post_rst_tick", 48, 32);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ball_physics.md
# ball_physics

Single-ball bounce engine for the 96x64 OLED paddle game. It sits directly downstream of the bar-position stage and consumes its registered bar column bounds (`x_left`, `x_right`) each game step. It produces ball position, score, lives and game-over status for the pixel renderer and the 7-segment score display. All motion advances only on a one-cycle `tick` strobe from the frame-rate divider.

## Interface
Parameters:
- `BAR_Y`, 58: OLED row occupied by the bar.
- `START_LIVES`, 3: lives loaded on reset and on restart (1..3).
- `MISS_TICKS`, 32: ticks spent in MISS before relaunch (1..255).

Ports:
- `clk` input 1: system clock.
- `reset` input 1: synchronous, active-high, dominates all other inputs.
- `tick` input 1: one-cycle game-step strobe.
- `start` input 1: debounced one-cycle launch/restart pulse.
- `x_left` input 7: bar left column, inclusive.
- `x_right` input 7: bar right column, inclusive.
- `ball_x` output 7: ball column, 0..95.
- `ball_y` output 6: ball row, 0..63.
- `score` output 8: bar hits, saturates at 255.
- `lives` output 2: remaining lives.
- `hit` output 1: one-cycle pulse on bar hit.
- `game_over` output 1: high while in OVER.

## Operation
- Reset values: ball (48,32), dx=+1, dy=+1, score 0, lives START_LIVES, hit 0, game_over 0, state IDLE.
- States: IDLE, PLAY, MISS, OVER. The state is internal only.
- IDLE: ball held at (48,32). A `start` pulse moves to PLAY with dx=+1 and dy=+1. `tick` is ignored.
- PLAY, evaluated on each `tick` using the current (pre-move) position:
  - Miss: if ball_y==63, lives decrement. If the new value is 0, go to OVER; otherwise go to MISS. Either way, park the ball at (48,32). No movement occurs on this tick.
  - X axis: if (ball_x==0 and dx<0) or (ball_x==95 and dx>0), flip dx, then move x by the new dx. Otherwise x+=dx.
  - Y axis:
    - Top: if ball_y==0 and dy<0, flip dy, then move.
    - Bar: if ball_y==BAR_Y-1, dy>0 and x_left<=ball_x<=x_right, flip dy, then move (y becomes BAR_Y-2). score+1 (saturating), and pulse `hit`.
    - Otherwise y+=dy. The ball passes the bar row when outside the bounds.
  - Corner case: X and Y reflections are independent and may both occur on one tick.
  - `x_left`/`x_right` are sampled on the tick cycle only.
- MISS: count MISS_TICKS ticks, then go to PLAY with dx unchanged and dy=+1. The ball stays parked until then.
- OVER: all outputs frozen and game_over=1. A `start` pulse reloads score 0 and lives START_LIVES, clears game_over, and enters PLAY from (48,32) with dx=+1 and dy=+1.
- `start` in PLAY or MISS is ignored. If `start` and `tick` coincide in IDLE/OVER, only the launch happens; no movement that cycle.
- Coordinate arithmetic is unsigned. The reflection checks above guarantee that x and y never wrap.

## Timing
- All outputs are registered. Effects of a tick or start appear on the cycle after the strobe.
- `hit` is high for exactly the one cycle following the hit tick.
- Latency: one tick produces one position step. There is no pipelining.
- If `reset` is asserted mid-operation, including on a tick cycle, reset values apply on the next edge. There is no partial update.

## Structure
- Shared game-constants include file holds:
  - SCREEN_W=96, SCREEN_H=64, CENTRE_X=48, CENTRE_Y=32.
  - The state encoding localparams, which the renderer also reads to blank the ball in OVER.
- Single flat module. The miss-hold counter is inline; no sub-module is warranted.

## Test plan
- Launch: reset, `start`, then 1 tick. Required: ball (49,33), score 0, lives 3.
- Bar hit: bar 65..79, start, 26 ticks. After tick 25 the ball is at (73,57). After tick 26: ball (74,56), score 1, `hit` high for one cycle.
- Right wall: continue the bar-hit case to tick 48. After tick 47 the ball is at (95,35). After tick 48: ball (94,34), moving left.
- Miss: bar 3..17, start, 32 ticks. After tick 31 the ball is at (79,63). After tick 32: lives 2, ball (48,32). After 32 more ticks: PLAY resumes. Next tick gives ball (49,33).
- Game over: three misses. Required: lives 0, game_over 1, outputs constant under further ticks. Then `start`: lives 3, score 0, game_over 0.
- Reset mid-play: assert `reset` together with `tick` at tick 10. Required: all reset values on the next cycle, and a further `tick` without `start` leaves the ball at (48,32).
